// File: rtl/obuf.sv
// Output buffer: captures one full result vector in a single parallel load,
// then streams the elements out over valid/ready, element 0 first.
module obuf #(
  parameter int unsigned datatype_size = 8,
  parameter int unsigned fifo_length   = 5,
  localparam int unsigned DataW = datatype_size * fifo_length,
  localparam int unsigned CntW  = $clog2(fifo_length + 1),
  localparam int unsigned IdxW  = (fifo_length > 1) ? $clog2(fifo_length) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic [DataW-1:0]         i_data,
  output logic                     o_load_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [datatype_size-1:0] o_data,
  output logic                     o_last,
  output logic [CntW-1:0]          o_count
);

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  state_e           state_q, state_d;
  logic [DataW-1:0] buf_q, buf_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  count_q, count_d;

  // Next-state: accept a load only when empty, advance on each completed transfer.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (i_load) begin
          buf_d   = i_data;
          idx_d   = '0;
          count_d = CntW'(fifo_length);
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (i_ready) begin
          if (count_q == CntW'(1)) begin
            // Final element leaves; index rewinds so the next vector starts at 0.
            idx_d   = '0;
            count_d = '0;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            count_d = count_q - CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset that also clears the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Outputs decoded from registered state only; data reads the array in place.
  always_comb begin
    o_load_ready = (state_q == StIdle);
    o_valid      = (state_q == StDrain);
    o_count      = count_q;
    o_last       = o_valid && (count_q == CntW'(1));
    o_data       = '0;
    if (o_valid) begin
      for (int k = 0; k < int'(fifo_length); k++) begin
        if (idx_q == IdxW'(k)) begin
          o_data = buf_q[k*datatype_size +: datatype_size];
        end
      end
    end
  end

endmodule

// File: tb/tb_obuf.sv
// Scoreboard bench for obuf: default build (5 elements) plus a 1-element build.
module tb_obuf;

  localparam int W = 8;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_load, i_ready;
  logic [W*N-1:0] i_data;
  logic           o_load_ready, o_valid, o_last;
  logic [W-1:0]   o_data;
  logic [2:0]     o_count;

  logic           i_load1, i_ready1;
  logic [W-1:0]   i_data1;
  logic           o_load_ready1, o_valid1, o_last1;
  logic [W-1:0]   o_data1;
  logic [0:0]     o_count1;

  always #5 clk = ~clk;

  obuf #(.datatype_size(W), .fifo_length(N)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (i_load),
    .i_data       (i_data),
    .o_load_ready (o_load_ready),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_count      (o_count)
  );

  obuf #(.datatype_size(W), .fifo_length(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (i_load1),
    .i_data       (i_data1),
    .o_load_ready (o_load_ready1),
    .o_valid      (o_valid1),
    .i_ready      (i_ready1),
    .o_data       (o_data1),
    .o_last       (o_last1),
    .o_count      (o_count1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] count;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor for the 5-element build: front of queue must be presented while valid.
  initial begin
    exp_t e;
    bit   last_seen;
    last_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_seen = 1'b0;
      end else begin
        if (last_seen) begin
          chk("bubble_valid", 32'(o_valid), 32'd0);
          chk("bubble_load_ready", 32'(o_load_ready), 32'd1);
          last_seen = 1'b0;
        end
        if (o_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 32'(o_valid), 32'd0);
          end else begin
            e = q[0];
            chk("data", 32'(o_data), 32'(e.data));
            chk("last", 32'(o_last), 32'(e.last));
            chk("count", 32'(o_count), 32'(e.count));
            if (i_ready) begin
              void'(q.pop_front());
              if (e.last) last_seen = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor for the 1-element build.
  initial begin
    exp_t e;
    bit   last_seen;
    last_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_seen = 1'b0;
      end else begin
        if (last_seen) begin
          chk("n1_bubble_valid", 32'(o_valid1), 32'd0);
          chk("n1_bubble_load_ready", 32'(o_load_ready1), 32'd1);
          last_seen = 1'b0;
        end
        if (o_valid1) begin
          if (q1.size() == 0) begin
            chk("n1_unexpected_valid", 32'(o_valid1), 32'd0);
          end else begin
            e = q1[0];
            chk("n1_data", 32'(o_data1), 32'(e.data));
            chk("n1_last", 32'(o_last1), 32'(e.last));
            chk("n1_count", 32'(o_count1), 32'(e.count));
            if (i_ready1) begin
              void'(q1.pop_front());
              if (e.last) last_seen = 1'b1;
            end
          end
        end
      end
    end
  end

  // Waits for load_ready, issues one load and queues the expected stream.
  task automatic do_load(input logic [W*N-1:0] v);
    exp_t e;
    int   t;
    t = 0;
    while (!o_load_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!o_load_ready) chk("load_ready_timeout", 32'(o_load_ready), 32'd1);
    i_data = v;
    i_load = 1'b1;
    for (int k = 0; k < N; k++) begin
      e.data  = v[k*W +: W];
      e.last  = (k == N - 1);
      e.count = 3'(N - k);
      q.push_back(e);
    end
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  // Drives i_ready from a repeating pattern until the scoreboard empties.
  task automatic drain(input logic [15:0] pat, output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 60) begin
      i_ready = pat[cyc % 16];
      @(posedge clk); #1;
      cyc++;
    end
    i_ready = 1'b0;
    if (q.size() != 0) chk("drain_timeout_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int   cyc;
    exp_t e;
    rst_n    = 1'b0;
    i_load   = 1'b0;
    i_ready  = 1'b0;
    i_data   = '0;
    i_load1  = 1'b0;
    i_ready1 = 1'b0;
    i_data1  = '0;

    // Reset held two cycles, then idle state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", 32'(o_load_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("n1_rst_load_ready", 32'(o_load_ready1), 32'd1);
    @(posedge clk); #1;

    // Basic drain with ready held high: exactly five transfer cycles.
    do_load({8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    chk("latency_valid", 32'(o_valid), 32'd1);
    chk("latency_data", 32'(o_data), 32'h11);
    chk("drain_load_ready", 32'(o_load_ready), 32'd0);
    drain(16'hFFFF, cyc);
    chk("full_rate_cycles", 32'(cyc), 32'd5);

    // Backpressure: ready pattern 1,0,0,1,0,1,1,0,...
    do_load({8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    drain(16'b1001_1010_0110_1001, cyc);

    // Load attempt while 0x22 is pending must be ignored.
    do_load({8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_load  = 1'b1;
    i_data  = {N{8'hAA}};
    repeat (2) @(posedge clk);
    #1 i_load = 1'b0;
    i_data = '0;
    drain(16'hFFFF, cyc);

    // Reset after two transfers discards the rest.
    do_load({8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_load_ready", 32'(o_load_ready), 32'd1);
    chk("midrst_data", 32'(o_data), 32'd0);
    do_load({8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    drain(16'hFFFF, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd5);

    // Single-element build: one transfer after a one-cycle stall.
    i_data1 = 8'h7E;
    i_load1 = 1'b1;
    e.data  = 8'h7E;
    e.last  = 1'b1;
    e.count = 3'd1;
    q1.push_back(e);
    @(posedge clk); #1;
    i_load1 = 1'b0;
    chk("n1_load_ready_busy", 32'(o_load_ready1), 32'd0);
    @(posedge clk); #1;
    i_ready1 = 1'b1;
    cyc = 0;
    while (q1.size() != 0 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    i_ready1 = 1'b0;
    chk("n1_drain_left", 32'(q1.size()), 32'd0);
    chk("n1_drain_cycles", 32'(cyc), 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
